// File: rtl/imm_pkg.sv
// Shared encodings and storage entry for the decode-stage immediate generator.
package imm_pkg;

  localparam logic [2:0] IMM_NONE  = 3'd0;
  localparam logic [2:0] IMM_I     = 3'd1;
  localparam logic [2:0] IMM_S     = 3'd2;
  localparam logic [2:0] IMM_B     = 3'd3;
  localparam logic [2:0] IMM_U     = 3'd4;
  localparam logic [2:0] IMM_J     = 3'd5;
  localparam logic [2:0] IMM_Z     = 3'd6;
  localparam logic [2:0] IMM_SHAMT = 3'd7;

  localparam int IMM_MAX_W = 64;
  localparam int TAG_MAX_W = 16;

  // Sized for the widest configuration; narrower builds leave upper bits at zero.
  typedef struct packed {
    logic [IMM_MAX_W-1:0] imm;
    logic [TAG_MAX_W-1:0] tag;
  } imm_entry_t;

endpackage

// File: rtl/imm_decode.sv
// Combinational immediate extraction and extension to XLEN bits.
module imm_decode
  import imm_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [31:7]     instr,
  input  logic [2:0]      imm_op,
  output logic [XLEN-1:0] imm
);

  always_comb begin
    imm = '0;
    case (imm_op)
      IMM_I:     imm = XLEN'($signed(instr[31:20]));
      IMM_S:     imm = XLEN'($signed({instr[31:25], instr[11:7]}));
      IMM_B:     imm = XLEN'($signed({instr[31], instr[7], instr[30:25], instr[11:8], 1'b0}));
      IMM_U:     imm = XLEN'($signed({instr[31:12], 12'b0}));
      IMM_J:     imm = XLEN'($signed({instr[31], instr[19:12], instr[20], instr[30:21], 1'b0}));
      IMM_Z:     imm = XLEN'(instr[19:15]);
      IMM_SHAMT: imm = (XLEN == 64) ? XLEN'(instr[25:20]) : XLEN'(instr[24:20]);
      default:   imm = '0;
    endcase
  end

endmodule

// File: rtl/imm_gen_stage.sv
// Registered immediate generator: decode on accept, then a two-entry skid
// buffer so out_ready never reaches in_ready combinationally.
module imm_gen_stage
  import imm_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int TAG_W = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_instr,
  input  logic [2:0]       in_imm_op,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_imm,
  output logic [TAG_W-1:0] out_tag
);

  generate
    if ((XLEN != 32 && XLEN != 64) || TAG_W < 1 || TAG_W > TAG_MAX_W) begin : g_bad_param
      $error("imm_gen_stage: XLEN must be 32 or 64 and TAG_W within 1..16");
    end
  endgenerate

  logic [XLEN-1:0] dec_imm;
  imm_entry_t      new_e, main_q, skid_q;
  logic            main_v, skid_v;
  logic            accept, pop;

  imm_decode #(.XLEN(XLEN)) u_dec (
    .instr  (in_instr[31:7]),
    .imm_op (in_imm_op),
    .imm    (dec_imm)
  );

  always_comb begin
    new_e                 = '0;
    new_e.imm[XLEN-1:0]   = dec_imm;
    new_e.tag[TAG_W-1:0]  = in_tag;
  end

  assign accept = in_valid && in_ready;
  assign pop    = main_v && out_ready;

  // in_ready is only ever low with skid full, so an accept never meets a full skid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_v <= 1'b0;
      skid_v <= 1'b0;
      main_q <= '0;
      skid_q <= '0;
    end else if (flush) begin
      main_v <= 1'b0;
      skid_v <= 1'b0;
    end else if (pop && skid_v) begin
      main_q <= skid_q;
      skid_v <= 1'b0;
    end else if (accept && (!main_v || pop)) begin
      main_q <= new_e;
      main_v <= 1'b1;
    end else if (accept) begin
      skid_q <= new_e;
      skid_v <= 1'b1;
    end else if (pop) begin
      main_v <= 1'b0;
    end
  end

  assign in_ready  = !skid_v;
  assign out_valid = main_v;
  assign out_imm   = main_q.imm[XLEN-1:0];
  assign out_tag   = main_q.tag[TAG_W-1:0];

  logic unused_bits;
  assign unused_bits = ^{in_instr[6:0], main_q.imm, main_q.tag};

endmodule

// File: tb/tb_imm_gen_stage.sv
// Bench: XLEN=32 and XLEN=64 instances share stimulus; a scoreboard queue
// holds expected entries from accept until they appear on the output.
module tb_imm_gen_stage;
  import imm_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic [31:0] in_instr = '0;
  logic [2:0]  in_imm_op = '0;
  logic [4:0]  in_tag = '0;
  logic        out_ready = 1'b0;

  logic        in_ready32, out_valid32, in_ready64, out_valid64;
  logic [31:0] out_imm32;
  logic [63:0] out_imm64;
  logic [4:0]  out_tag32, out_tag64;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [31:0] i32;
    logic [63:0] i64;
    logic [4:0]  tag;
  } exp_t;
  exp_t q[$];

  always #5 clk = ~clk;

  imm_gen_stage #(.XLEN(32), .TAG_W(5)) dut32 (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready32),
    .in_instr(in_instr), .in_imm_op(in_imm_op), .in_tag(in_tag), .out_valid(out_valid32),
    .out_ready(out_ready), .out_imm(out_imm32), .out_tag(out_tag32)
  );

  imm_gen_stage #(.XLEN(64), .TAG_W(5)) dut64 (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready64),
    .in_instr(in_instr), .in_imm_op(in_imm_op), .in_tag(in_tag), .out_valid(out_valid64),
    .out_ready(out_ready), .out_imm(out_imm64), .out_tag(out_tag64)
  );

  task automatic chk(input string nm, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", nm, obs, exp);
    end
  endtask

  // Reference built from arithmetic shifts of the sign-extended word.
  function automatic logic [63:0] ref_imm(input logic [31:0] ins, input logic [2:0] op, input bit x64);
    logic signed [63:0] s, t;
    logic [63:0] r;
    s = $signed({{32{ins[31]}}, ins});
    t = s >>> 20;
    case (op)
      IMM_I:     r = t;
      IMM_S:     r = (t & ~64'h1F) | 64'(ins[11:7]);
      IMM_B:     r = (t & ~64'h81F) | (64'(ins[7]) << 11) | (64'(ins[11:8]) << 1);
      IMM_U:     r = s & ~64'hFFF;
      IMM_J:     r = (t & ~64'hFFFFF) | (64'({ins[19:12], ins[20]}) << 11) | (t & 64'h7FE);
      IMM_Z:     r = 64'(ins[19:15]);
      IMM_SHAMT: r = x64 ? 64'(ins[25:20]) : 64'(ins[24:20]);
      default:   r = '0;
    endcase
    return r;
  endfunction

  always @(negedge clk) begin
    if (!rst_n) begin
      q.delete();
    end else begin
      if (out_valid32 && out_ready && !flush) begin
        chk("sb_nonempty", 64'(q.size() != 0), 64'd1);
        if (q.size() != 0) begin
          exp_t e;
          e = q.pop_front();
          chk("imm32", 64'(out_imm32), 64'(e.i32));
          chk("imm64", out_imm64, e.i64);
          chk("tag32", 64'(out_tag32), 64'(e.tag));
          chk("tag64", 64'(out_tag64), 64'(e.tag));
          chk("valid64", 64'(out_valid64), 64'd1);
        end
      end
      if (flush) q.delete();
    end
  end

  task automatic send(input logic [31:0] ins, input logic [2:0] op, input logic [4:0] tg,
                      input logic [31:0] e32, input logic [63:0] e64);
    bit ok;
    exp_t e;
    ok = 0;
    in_valid = 1'b1; in_instr = ins; in_imm_op = op; in_tag = tg;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (in_ready32) begin ok = 1; break; end
    end
    chk("send_accept", 64'(ok), 64'd1);
    if (ok) begin
      e.i32 = e32; e.i64 = e64; e.tag = tg;
      q.push_back(e);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic push_now(input logic [31:0] ins, input logic [2:0] op, input logic [4:0] tg);
    exp_t e;
    e.i32 = ref_imm(ins, op, 0) & 64'hFFFF_FFFF;
    e.i64 = ref_imm(ins, op, 1);
    e.tag = tg;
    q.push_back(e);
  endtask

  task automatic check_reset_vals(input string nm);
    chk({nm, "_out_valid"}, 64'(out_valid32), 64'd0);
    chk({nm, "_in_ready"}, 64'(in_ready32), 64'd1);
    chk({nm, "_out_imm32"}, 64'(out_imm32), 64'd0);
    chk({nm, "_out_imm64"}, out_imm64, 64'd0);
    chk({nm, "_out_tag"}, 64'(out_tag32), 64'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] ri;
    logic [2:0]  rop;
    logic [4:0]  rtag;
    int n, hold;
    bit acc, did_rst;

    // Reset state
    repeat (3) @(negedge clk);
    check_reset_vals("reset");
    @(posedge clk); #1;
    rst_n = 1'b1;
    out_ready = 1'b1;

    // Directed decodes
    send(32'hFFF00093, IMM_I, 5'd7, 32'hFFFFFFFF, 64'hFFFFFFFF_FFFFFFFF);
    @(negedge clk);
    chk("I_latency_valid", 64'(out_valid32), 64'd1);
    chk("I_imm", 64'(out_imm32), 64'hFFFFFFFF);
    chk("I_tag", 64'(out_tag32), 64'd7);
    @(posedge clk); #1;
    send(32'hFE000EE3, IMM_B, 5'd1, 32'hFFFFFFFC, 64'hFFFFFFFF_FFFFFFFC);
    send(32'h0080006F, IMM_J, 5'd2, 32'h00000008, 64'h8);
    send(32'h800000B7, IMM_U, 5'd3, 32'h80000000, 64'hFFFFFFFF_80000000);
    send(32'h03F09093, IMM_SHAMT, 5'd4, 32'd31, 64'd63);
    send(32'h000FD073, IMM_Z, 5'd5, 32'd31, 64'd31);
    send(32'hFE112E23, IMM_S, 5'd6, 32'hFFFFFFFC, 64'hFFFFFFFF_FFFFFFFC);
    send(32'hFFFFFFFF, IMM_NONE, 5'd8, 32'd0, 64'd0);
    repeat (2) @(posedge clk); #1;
    chk("directed_drained", 64'(q.size()), 64'd0);

    // Back-pressure: tags 1,2 accepted, 3 held until out_ready returns
    out_ready = 1'b0;
    in_valid = 1'b1; in_instr = 32'h00100093; in_imm_op = IMM_I; in_tag = 5'd1;
    @(negedge clk); chk("bp_rdy1", 64'(in_ready32), 64'd1); push_now(in_instr, in_imm_op, in_tag);
    @(posedge clk); #1; in_instr = 32'h00200093; in_tag = 5'd2;
    @(negedge clk); chk("bp_rdy2", 64'(in_ready32), 64'd1); push_now(in_instr, in_imm_op, in_tag);
    @(posedge clk); #1; in_instr = 32'h00300093; in_tag = 5'd3;
    @(negedge clk); chk("bp_rdy3_low", 64'(in_ready32), 64'd0);
    chk("bp_hold_tag", 64'(out_tag32), 64'd1);
    @(posedge clk); #1; out_ready = 1'b1;
    @(negedge clk); chk("bp_rdy_still_low", 64'(in_ready32), 64'd0);
    chk("bp_out1", 64'({out_valid32, out_tag32}), 64'({1'b1, 5'd1}));
    @(posedge clk); #1;
    @(negedge clk); chk("bp_rdy_back", 64'(in_ready32), 64'd1); push_now(in_instr, in_imm_op, in_tag);
    chk("bp_out2", 64'({out_valid32, out_tag32}), 64'({1'b1, 5'd2}));
    @(posedge clk); #1; in_valid = 1'b0;
    @(negedge clk); chk("bp_out3", 64'({out_valid32, out_tag32}), 64'({1'b1, 5'd3}));
    @(posedge clk); #1;

    // Flush with both entries full and an offered input
    out_ready = 1'b0;
    in_valid = 1'b1; in_instr = 32'h00A00093; in_imm_op = IMM_I; in_tag = 5'd10;
    @(negedge clk); push_now(in_instr, in_imm_op, in_tag);
    @(posedge clk); #1; in_instr = 32'h00B00093; in_tag = 5'd11;
    @(negedge clk); push_now(in_instr, in_imm_op, in_tag);
    @(posedge clk); #1; in_instr = 32'h00C00093; in_tag = 5'd12; flush = 1'b1;
    @(negedge clk); chk("fl_full_rdy", 64'(in_ready32), 64'd0);
    @(posedge clk); #1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    chk("fl_out_valid", 64'(out_valid32), 64'd0);
    chk("fl_in_ready", 64'(in_ready32), 64'd1);
    // Flush while an accept would otherwise land in main
    @(posedge clk); #1; in_valid = 1'b1; in_instr = 32'h00D00093; in_tag = 5'd13; flush = 1'b1;
    @(posedge clk); #1; flush = 1'b0; in_valid = 1'b0;
    @(negedge clk); chk("fl_drop_accept", 64'(out_valid32), 64'd0);
    repeat (2) @(posedge clk); #1;

    // Randomised traffic with a mid-stream reset
    n = 0; hold = 0; acc = 0; did_rst = 0;
    while (n < 10000) begin
      @(posedge clk); #1;
      if (!rst_n) rst_n = 1'b1;
      if (acc) begin in_valid = 1'b0; acc = 0; n++; hold = 0; end
      if (n == 5000 && !did_rst) begin rst_n = 1'b0; did_rst = 1; end
      if (!in_valid && $urandom_range(0, 3) != 0) begin
        ri = $urandom; rop = 3'($urandom_range(0, 7)); rtag = 5'($urandom);
        in_valid = 1'b1; in_instr = ri; in_imm_op = rop; in_tag = rtag;
      end
      out_ready = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      if (!rst_n) begin
        check_reset_vals("midreset");
      end else if (in_valid && in_ready32) begin
        push_now(in_instr, in_imm_op, in_tag);
        acc = 1;
      end else if (in_valid) begin
        hold++;
        if (hold > 100) begin
          chk("rand_stall", 64'(in_ready32), 64'd1);
          in_valid = 1'b0; hold = 0;
        end
      end
    end
    @(posedge clk); #1;
    in_valid = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < 10 && q.size() != 0; i++) @(posedge clk);
    #1;
    chk("rand_drained", 64'(q.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/imm_gen_stage.md
# imm_gen_stage

Registered, parametrised immediate generator for the decode stage. Extracts and sign- or zero-extends the immediate for I/S/B/U/J formats, plus CSR zimm and shift-amount formats, to XLEN bits. Results are delivered through a valid/ready pipeline stage with a two-entry skid buffer, so back-pressure from execute never creates a combinational path back to fetch. It sits between instruction fetch/decode control and the operand mux of execute.

## Interface
- `XLEN`, default 32: output width, 32 or 64; any other value is a synthesis error.
- `TAG_W`, default 5: width of sideband tag (e.g. rd / ROB id) carried with each immediate.
- `clk` input 1: single clock, rising edge.
- `rst_n` input 1: reset, asynchronous, active-low.
- `flush` input 1: synchronous kill of all held and incoming entries.
- `in_valid` input 1: upstream offers an instruction.
- `in_ready` output 1: stage can accept; registered.
- `in_instr` input 32: raw instruction; bits [6:0] are ignored.
- `in_imm_op` input 3: format select, encodings in Structure.
- `in_tag` input TAG_W: sideband, passed through unchanged.
- `out_valid` output 1: `out_imm`/`out_tag` valid.
- `out_ready` input 1: downstream accepts.
- `out_imm` output XLEN: extended immediate.
- `out_tag` output TAG_W: tag of the entry on `out_imm`.

## Operation
- Decode, all sign extensions from instr[31] to XLEN:
  - I: instr[31:20].
  - S: {instr[31:25], instr[11:7]}.
  - B: {instr[31], instr[7], instr[30:25], instr[11:8], 0}.
  - U: {instr[31:12], 12'b0}, sign-extended when XLEN=64.
  - J: {instr[31], instr[19:12], instr[20], instr[30:21], 0}.
- Zero-extended formats:
  - Z (CSR zimm): zero-extend instr[19:15].
  - SHAMT: zero-extend instr[25:20] when XLEN=64, instr[24:20] when XLEN=32.
  - NONE: 0.
- Decoded value is computed at accept time and stored. Held entries never re-decode.
- Storage is a main register (drives outputs) and a skid register.
- Accept happens when `in_valid && in_ready`:
  - Main empty, or main popping this cycle: the entry goes to main.
  - Otherwise the entry goes to skid.
- Pop happens when `out_valid && out_ready`. If skid is full, skid moves to main in the same edge.
- `in_ready` next = skid empty after this edge's updates.
- `flush` wins over everything: both entries are invalidated, any same-cycle accept is dropped, and `in_ready` is 1 next cycle. Data registers may keep stale values.
- Order is strictly FIFO. No entry is lost or duplicated under any `in_valid`/`out_ready` pattern.

## Timing
- Latency: accept at edge N, then `out_valid`=1 from edge N (visible in cycle N+1).
- Throughput: 1 per cycle while `out_ready`=1.
- `out_valid`, `out_imm`, `out_tag` are stable while `out_valid && !out_ready`.
- Upstream must hold `in_instr`/`in_imm_op`/`in_tag` only while `in_valid && !in_ready`.
- Reset values: `out_valid`=0, `in_ready`=1, `out_imm`=0, `out_tag`=0. Skid is invalid.
- Reset asserted mid-transfer discards all entries immediately; there are no partial outputs.
- Both entries full with `out_ready`=1 and `in_valid`=1 in the same cycle: pop main, skid moves to main, no accept (`in_ready` was 0). `in_ready` is 1 next cycle.

## Structure
- Package `imm_pkg`:
  - Formats `IMM_NONE`=0, `IMM_I`=1, `IMM_S`=2, `IMM_B`=3, `IMM_U`=4, `IMM_J`=5, `IMM_Z`=6, `IMM_SHAMT`=7.
  - Entry struct {imm, tag}.
- Sub-module `imm_decode`: purely combinational, parameter XLEN, instantiated once on the input side.
- Top holds the two-entry skid control only.

## Test plan
- Reset, then I, XLEN=32: `0xFFF00093`/`IMM_I` → `out_imm`=`0xFFFFFFFF` one cycle later, tag preserved.
- B: `0xFE000EE3`/`IMM_B` → `0xFFFFFFFC`. Also check J for `0x0080006F` → `0x00000008`.
- XLEN=64:
  - `0x800000B7`/`IMM_U` → `0xFFFFFFFF80000000`.
  - `0x03F09093`/`IMM_SHAMT` → 63.
  - `0x000FD073`/`IMM_Z` → 31.
- Back-pressure: `out_ready`=0 for 3 cycles, offer tags 1,2,3 back-to-back.
  - Tags 1 and 2 are accepted; `in_ready` falls after 2; tag 3 is held upstream.
  - Release `out_ready`: outputs 1,2,3 in order, no gaps.
- Flush with both entries full and `in_valid`=1 → next cycle `out_valid`=0, `in_ready`=1, flushed input never appears.
- Randomised valid/ready against a scoreboard for 10k transactions, plus `rst_n` pulsed mid-stream → no loss, duplication or reorder; reset values as specified.
